config_loader: RTL and testbench

Bitstream loader that drives the serial configuration chain formed by the daisy-chained `io_block` / `shift_reg` cells. It accepts configuration bytes over a valid/ready stream, serialises them LSB-first onto `prog_in` while generating `prog_clk` and `prog_en`, and stops after exactly `CHAIN_LEN` bits. The previous chain contents, shifted out on `prog_out`, are captured and returned as readback bytes. It sits directly upstream of the first cell's `prog_in` and receives the last cell's `prog_out`.

---
 rtl/config_loader.sv | 118 +++++++++++
 tb/tb_config_loader.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/config_loader.sv
// Serial configuration-chain loader: streams bytes LSB-first onto prog_in
// with a generated prog_clk, and returns the displaced chain bits as bytes.
module config_loader #(
    parameter int CHAIN_LEN = 48
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic       prog_in,
    output logic       prog_clk,
    output logic       prog_en,
    input  logic       prog_out,
    output logic [7:0] rb_data,
    output logic       rb_valid,
    output logic       busy,
    output logic       done
);

    // at least 3 bits so the low bits always give the byte position
    localparam int CW = ($clog2(CHAIN_LEN + 1) < 3) ? 3 : $clog2(CHAIN_LEN + 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOW,
        HIGH,
        DONE
    } state_t;

    state_t        state;
    state_t        next;
    logic [7:0]    shifter;
    logic [7:0]    rb_shift;
    logic [2:0]    byte_bit;
    logic [CW-1:0] bit_cnt;
    logic [2:0]    rb_pos;
    logic          last_bit;

    assign rb_pos   = bit_cnt[2:0];
    assign last_bit = (bit_cnt == CW'(CHAIN_LEN - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    always_comb begin
        next = state;
        unique case (state)
            IDLE:  if (start) next = FETCH;
            FETCH: if (s_valid) next = LOW;
            LOW:   next = HIGH;
            HIGH: begin
                if (last_bit)            next = DONE;
                else if (byte_bit == 3'd7) next = FETCH;
                else                     next = LOW;
            end
            DONE:  next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shifter  <= 8'd0;
            rb_shift <= 8'd0;
            rb_data  <= 8'd0;
            rb_valid <= 1'b0;
            byte_bit <= 3'd0;
            bit_cnt  <= '0;
        end else begin
            rb_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        bit_cnt  <= '0;
                        rb_shift <= 8'd0;
                    end
                end
                FETCH: begin
                    if (s_valid) begin
                        shifter  <= s_data;
                        byte_bit <= 3'd0;
                    end
                end
                LOW: begin
                    // full byte or final chain bit: emit and restart zero-padded
                    if (rb_pos == 3'd7 || last_bit) begin
                        rb_data  <= rb_shift | ({7'd0, prog_out} << rb_pos);
                        rb_valid <= 1'b1;
                        rb_shift <= 8'd0;
                    end else begin
                        rb_shift[rb_pos] <= prog_out;
                    end
                end
                HIGH: begin
                    bit_cnt <= bit_cnt + CW'(1);
                    if (!last_bit && byte_bit != 3'd7) begin
                        shifter  <= {1'b0, shifter[7:1]};
                        byte_bit <= byte_bit + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state == FETCH) || (state == LOW) || (state == HIGH);
    assign prog_en  = busy;
    assign s_ready  = (state == FETCH);
    assign prog_clk = (state == HIGH);
    assign done     = (state == DONE);
    assign prog_in  = shifter[0] & ((state == LOW) || (state == HIGH));

endmodule

// File: tb/tb_config_loader.sv
// Scoreboard bench: a 48-bit and a 13-bit loader share one byte stream,
// each driving a behavioural bit-FIFO chain model.
module tb_config_loader;

    localparam int LA = 48;
    localparam int LB = 13;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] s_data;
    logic       s_valid;
    logic [1:0] s_ready, prog_in, prog_clk, prog_en, rb_valid, busy, done;
    logic [1:0] po = 2'b00;
    logic [7:0] rb_data [2];

    int checks = 0;
    int errors = 0;
    bit tmo = 0, tmo_seen = 0, fin = 0, fin_seen = 0;

    bit         eb [2][$];
    logic [7:0] er [2][$];
    int         ed [2][$];
    int         eu [2][$];
    bit         ch [2][$];
    int         len [2] = '{LA, LB};
    int         busy_n [2] = '{0, 0};
    logic [1:0] pclk_q = 2'b00;
    logic       rst_q = 1'b0;

    always #5 clk = ~clk;

    config_loader #(.CHAIN_LEN(LA)) u_a (
        .clk(clk), .rst(rst), .start(start), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready[0]), .prog_in(prog_in[0]), .prog_clk(prog_clk[0]),
        .prog_en(prog_en[0]), .prog_out(po[0]), .rb_data(rb_data[0]),
        .rb_valid(rb_valid[0]), .busy(busy[0]), .done(done[0])
    );

    config_loader #(.CHAIN_LEN(LB)) u_b (
        .clk(clk), .rst(rst), .start(start), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready[1]), .prog_in(prog_in[1]), .prog_clk(prog_clk[1]),
        .prog_en(prog_en[1]), .prog_out(po[1]), .rb_data(rb_data[1]),
        .rb_valid(rb_valid[1]), .busy(busy[1]), .done(done[1])
    );

    task automatic chk(input bit ok, input string name, input longint act,
                       input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // monitor: samples at negedge, pops expectations as the DUTs present them
    always @(negedge clk) begin
        int cyc;
        bit b;
        logic [7:0] v;
        int e;
        cyc = int'($time / 10);
        if (tmo && !tmo_seen) begin
            chk(1'b0, "handshake_timeout", 0, 1);
            tmo_seen = 1;
        end
        for (int g = 0; g < 2; g++) begin
            if (rst_q) begin
                chk({s_ready[g], prog_in[g], prog_clk[g], prog_en[g], rb_valid[g],
                     busy[g], done[g]} == 7'd0 && rb_data[g] == 8'd0, "reset_out",
                    {s_ready[g], prog_in[g], prog_clk[g], prog_en[g], rb_valid[g],
                     busy[g], done[g], rb_data[g]}, 0);
                busy_n[g] = 0;
            end
            if (prog_clk[g] && !pclk_q[g]) begin
                if (!rst) begin
                    if (eb[g].size() == 0) begin
                        chk(1'b0, "extra_prog_clk", g, 0);
                    end else begin
                        b = eb[g].pop_front();
                        chk(prog_in[g] == b, "prog_in_bit", prog_in[g], b);
                    end
                end
                ch[g].push_back(prog_in[g]);
                void'(ch[g].pop_front());
            end
            po[g] = ch[g][0];
            if (busy[g] || prog_en[g] || s_ready[g] || prog_clk[g])
                chk(prog_en[g] == busy[g] && busy[g], "ctl_when_idle",
                    {prog_en[g], busy[g], s_ready[g], prog_clk[g]}, 4'b1100);
            if (busy[g]) busy_n[g]++;
            if (rb_valid[g] && !rst) begin
                if (er[g].size() == 0) begin
                    chk(1'b0, "extra_rb_valid", rb_data[g], 0);
                end else begin
                    v = er[g].pop_front();
                    chk(rb_data[g] == v, "rb_data", rb_data[g], v);
                end
            end
            if (done[g] && !rst) begin
                if (ed[g].size() == 0) begin
                    chk(1'b0, "extra_done", cyc, 0);
                end else begin
                    e = ed[g].pop_front();
                    chk(cyc == e, "done_cycle", cyc, e);
                    e = eu[g].pop_front();
                    chk(busy_n[g] == e, "busy_cycles", busy_n[g], e);
                end
                chk(eb[g].size() == 0 && er[g].size() == 0, "leftover_at_done",
                    eb[g].size() + er[g].size(), 0);
                busy_n[g] = 0;
            end
        end
        if (fin && !fin_seen) begin
            for (int g = 0; g < 2; g++)
                chk(ed[g].size() + eb[g].size() + er[g].size() == 0, "drain",
                    ed[g].size() + eb[g].size() + er[g].size(), 0);
            fin_seen = 1;
        end
        rst_q  = rst;
        pclk_q = prog_clk;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic int cyc_now();
        return int'(($time + 5) / 10);
    endfunction

    // one load: model predicts accept cycles, bit stream, readback and done cycle
    task automatic load(input logic [7:0] bytes [6], input int gp [6],
                        input bit pulse, input int rst_at);
        int s, fe, n, r, idx, nb;
        int a [6];
        int t [6];
        int d [2];
        logic [7:0] v;
        nb = 0;
        while ((busy != 2'b00 || done != 2'b00) && nb < 300) begin
            step();
            nb++;
        end
        s = cyc_now();
        fe = s + 1;
        for (int i = 0; i < 6; i++) begin
            t[i] = fe + gp[i];
            a[i] = (t[i] > fe) ? t[i] : fe;
            fe = a[i] + 17;
        end
        for (int g = 0; g < 2; g++) begin
            n = (len[g] + 7) / 8;
            r = len[g] - 8 * (n - 1);
            d[g] = a[n-1] + 2 * r + 1;
            ed[g].push_back(d[g]);
            eu[g].push_back(d[g] - s - 1);
            for (int i = 0; i < len[g]; i++) eb[g].push_back(bytes[i/8][i%8]);
            for (int j = 0; j < n; j++) begin
                v = 8'd0;
                for (int k = 0; k < 8; k++) begin
                    idx = 8 * j + k;
                    if (idx < len[g]) v[k] = ch[g][idx];
                end
                er[g].push_back(v);
            end
        end
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (rst_at > 0 && i == 3) begin
                while (cyc_now() < s + rst_at) step();
                rst = 1'b1;
                for (int g = 0; g < 2; g++) begin
                    eb[g].delete();
                    er[g].delete();
                    ed[g].delete();
                    eu[g].delete();
                end
                step();
                rst = 1'b0;
                step();
                return;
            end
            if (pulse && i == 2) begin
                while (cyc_now() < d[1]) step();
                start = 1'b1;
                step();
                start = 1'b0;
            end
            while (cyc_now() < t[i]) step();
            s_valid = 1'b1;
            s_data  = bytes[i];
            nb = 0;
            while (!s_ready[0] && nb < 300) begin
                step();
                nb++;
            end
            if (!s_ready[0]) begin
                tmo = 1;
                s_valid = 1'b0;
                return;
            end
            step();
            s_valid = 1'b0;
            s_data  = 8'($urandom);
        end
        while (cyc_now() < d[0] + 2) step();
    endtask

    initial begin
        logic [7:0] bytes [6];
        int gp [6];
        rst = 1'b1;
        start = 1'b0;
        s_valid = 1'b0;
        s_data = 8'd0;
        for (int g = 0; g < 2; g++)
            for (int i = 0; i < len[g]; i++) ch[g].push_back(1'($urandom));
        repeat (3) step();
        rst = 1'b0;
        step();

        bytes = '{8'hA5, 8'h3C, 8'h5A, 8'hC3, 8'h0F, 8'hF0};
        gp = '{0, 0, 0, 0, 0, 0};
        load(bytes, gp, 1'b0, 0);

        bytes = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        gp = '{0, 0, 0, 10, 0, 0};
        load(bytes, gp, 1'b0, 0);

        for (int i = 0; i < 6; i++) bytes[i] = 8'($urandom);
        gp = '{0, 0, 0, 0, 0, 0};
        load(bytes, gp, 1'b1, 0);

        for (int i = 0; i < 6; i++) bytes[i] = 8'($urandom);
        load(bytes, gp, 1'b0, 44);

        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 6; i++) begin
                bytes[i] = 8'($urandom);
                gp[i] = int'($urandom_range(0, 12)) - 6;
            end
            load(bytes, gp, 1'b0, 0);
        end

        repeat (3) step();
        fin = 1;
        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
